// File: rtl/time_align_pkg.sv
// rtl/time_align_pkg.sv - shared constants, types and slice helper for the N-stage time aligner
package time_align_pkg;

  localparam int TA_NUM_STAGES = 4;
  localparam int TA_SLICE_W    = 3;
  localparam int TA_CNT_W      = 8;

  typedef logic [TA_CNT_W-1:0] ta_cnt_t;

  // Bit offset of slice k in the packed word; slice 0 occupies the MSBs.
  function automatic int slice_lsb(input int k, input int num_stages, input int slice_w);
    return (num_stages - 1 - k) * slice_w;
  endfunction

endpackage

// File: rtl/ta_delay_line.sv
// rtl/ta_delay_line.sv - fixed-depth shift register with a hold enable
module ta_delay_line #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] taps [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) taps[i] <= '0;
    end else if (en) begin
      taps[0] <= din;
      for (int i = 1; i < DEPTH; i++) taps[i] <= taps[i-1];
    end
  end

  assign dout = taps[DEPTH-1];

endmodule

// File: rtl/time_align_nstage.sv
// rtl/time_align_nstage.sv - re-aligns a word whose slices arrive one cycle apart, with tag checking
module time_align_nstage
  import time_align_pkg::*;
#(
  parameter int NUM_STAGES = TA_NUM_STAGES,
  parameter int SLICE_W    = TA_SLICE_W,
  parameter int CNT_W      = TA_CNT_W
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic [NUM_STAGES*SLICE_W-1:0] slice_i,
  input  logic [NUM_STAGES-1:0]         valid_i,
  input  logic                          stall_i,
  input  logic                          bypass_i,
  input  logic                          clr_err_i,
  output logic [NUM_STAGES*SLICE_W-1:0] dout_o,
  output logic                          valid_o,
  output logic [SLICE_W-1:0]            head_o,
  output logic                          err_o,
  output logic [CNT_W-1:0]              err_cnt_o,
  output logic                          primed_o
);

  localparam int WORD_W = NUM_STAGES * SLICE_W;
  localparam int FILL_W = $clog2(NUM_STAGES + 1);

  logic [WORD_W-1:0]     aligned;
  logic [NUM_STAGES-1:0] aligned_tag;
  logic [WORD_W-1:0]     sel_data;
  logic [NUM_STAGES-1:0] sel_tag;
  logic                  valid_n;
  logic                  err_n;
  logic [FILL_W-1:0]     fill_cnt;

  // Slice k waits NUM_STAGES-1-k cycles here; the output register adds the last one.
  for (genvar k = 0; k < NUM_STAGES; k++) begin : g_slice
    localparam int LSB   = slice_lsb(k, NUM_STAGES, SLICE_W);
    localparam int DEPTH = NUM_STAGES - 1 - k;
    if (DEPTH > 0) begin : g_dly
      logic [SLICE_W:0] dl_out;
      ta_delay_line #(.DEPTH(DEPTH), .WIDTH(SLICE_W + 1)) u_dly (
        .clk  (clk_i),
        .rst_n(reset_i),
        .en   (~stall_i),
        .din  ({valid_i[k], slice_i[LSB +: SLICE_W]}),
        .dout (dl_out)
      );
      assign aligned[LSB +: SLICE_W] = dl_out[SLICE_W-1:0];
      assign aligned_tag[k]          = dl_out[SLICE_W];
    end else begin : g_thru
      assign aligned[LSB +: SLICE_W] = slice_i[LSB +: SLICE_W];
      assign aligned_tag[k]          = valid_i[k];
    end
  end

  assign sel_data = bypass_i ? slice_i : aligned;
  assign sel_tag  = bypass_i ? valid_i : aligned_tag;
  assign valid_n  = &sel_tag;
  assign err_n    = (|sel_tag) & ~valid_n;

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      dout_o   <= '0;
      valid_o  <= 1'b0;
      err_o    <= 1'b0;
      head_o   <= '0;
      fill_cnt <= '0;
    end else if (!stall_i) begin
      dout_o  <= sel_data;
      valid_o <= valid_n;
      err_o   <= err_n;
      head_o  <= slice_i[WORD_W-1 -: SLICE_W];
      if (fill_cnt != FILL_W'(NUM_STAGES)) fill_cnt <= fill_cnt + 1'b1;
    end
  end

  // Clear acts even while stalled and beats a same-edge increment.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      err_cnt_o <= '0;
    end else if (clr_err_i) begin
      err_cnt_o <= '0;
    end else if (!stall_i && err_n && (err_cnt_o != {CNT_W{1'b1}})) begin
      err_cnt_o <= err_cnt_o + 1'b1;
    end
  end

  assign primed_o = (fill_cnt == FILL_W'(NUM_STAGES));

endmodule

// File: tb/tb_time_align_nstage.sv
// tb/tb_time_align_nstage.sv - table-driven bench for time_align_nstage
module tb_time_align_nstage;
  import time_align_pkg::*;

  localparam int N = 4;
  localparam int W = 3;
  localparam int L = 16;

  logic            clk = 1'b0;
  logic            reset_i;
  logic [N*W-1:0]  slice_i;
  logic [N-1:0]    valid_i;
  logic            stall_i;
  logic            bypass_i;
  logic            clr_err_i;
  logic [N*W-1:0]  dout_o;
  logic            valid_o;
  logic [W-1:0]    head_o;
  logic            err_o;
  ta_cnt_t         err_cnt_o;
  logic            primed_o;

  time_align_nstage dut (
    .clk_i    (clk),
    .reset_i  (reset_i),
    .slice_i  (slice_i),
    .valid_i  (valid_i),
    .stall_i  (stall_i),
    .bypass_i (bypass_i),
    .clr_err_i(clr_err_i),
    .dout_o   (dout_o),
    .valid_o  (valid_o),
    .head_o   (head_o),
    .err_o    (err_o),
    .err_cnt_o(err_cnt_o),
    .primed_o (primed_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N*W-1:0] word;
    logic [N-1:0]   tag;
    logic [N*W-1:0] exp_dout;
    logic           exp_valid;
    logic           exp_err;
    ta_cnt_t        exp_cnt;
  } vec_t;

  vec_t tbl [L];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Staggered front-end: in cycle c, slice k belongs to word c-k.
  task automatic drive_stream(input int c);
    int j;
    slice_i = '0;
    valid_i = '0;
    for (int k = 0; k < N; k++) begin
      j = c - k;
      if (j >= 0 && j < L) begin
        slice_i[(N-1-k)*W +: W] = tbl[j].word[(N-1-k)*W +: W];
        valid_i[k]              = tbl[j].tag[k];
      end
    end
  endtask

  task automatic check_word(input string tag, input int idx);
    chk({tag, "_dout"},  32'(dout_o),    32'(tbl[idx].exp_dout));
    chk({tag, "_valid"}, 32'(valid_o),   32'(tbl[idx].exp_valid));
    chk({tag, "_err"},   32'(err_o),     32'(tbl[idx].exp_err));
    chk({tag, "_cnt"},   32'(err_cnt_o), 32'(tbl[idx].exp_cnt));
  endtask

  initial begin
    logic [W-1:0]   head_exp;
    logic [N*W-1:0] raw;
    int             c;
    int             stalls;

    reset_i = 1'b0; slice_i = '0; valid_i = '0;
    stall_i = 1'b0; bypass_i = 1'b0; clr_err_i = 1'b0;

    tbl[0]  = '{12'hABC, 4'hF, 12'hABC, 1'b1, 1'b0, 8'd0};
    tbl[1]  = '{12'h123, 4'hF, 12'h123, 1'b1, 1'b0, 8'd0};
    tbl[2]  = '{12'h456, 4'hF, 12'h456, 1'b1, 1'b0, 8'd0};
    tbl[3]  = '{12'h789, 4'hF, 12'h789, 1'b1, 1'b0, 8'd0};
    tbl[4]  = '{12'h5A5, 4'hB, 12'h5A5, 1'b0, 1'b1, 8'd1};
    tbl[5]  = '{12'hFFF, 4'hF, 12'hFFF, 1'b1, 1'b0, 8'd1};
    tbl[6]  = '{12'h000, 4'hF, 12'h000, 1'b1, 1'b0, 8'd1};
    tbl[7]  = '{12'h001, 4'h0, 12'h001, 1'b0, 1'b0, 8'd1};
    tbl[8]  = '{12'h800, 4'h1, 12'h800, 1'b0, 1'b1, 8'd2};
    tbl[9]  = '{12'h3C3, 4'hF, 12'h3C3, 1'b1, 1'b0, 8'd2};
    tbl[10] = '{12'h777, 4'h8, 12'h777, 1'b0, 1'b1, 8'd3};
    tbl[11] = '{12'h246, 4'hF, 12'h246, 1'b1, 1'b0, 8'd3};
    tbl[12] = '{12'h9DB, 4'hE, 12'h9DB, 1'b0, 1'b1, 8'd4};
    tbl[13] = '{12'h135, 4'hF, 12'h135, 1'b1, 1'b0, 8'd4};
    tbl[14] = '{12'hACE, 4'hF, 12'hACE, 1'b1, 1'b0, 8'd4};
    tbl[15] = '{12'hFED, 4'hF, 12'hFED, 1'b1, 1'b0, 8'd4};

    // Reset state, then priming on exactly the 4th edge.
    slice_i = 12'hFFF; valid_i = 4'hF;
    repeat (2) step();
    chk("rst_dout",   32'(dout_o),    32'h0);
    chk("rst_valid",  32'(valid_o),   32'h0);
    chk("rst_err",    32'(err_o),     32'h0);
    chk("rst_cnt",    32'(err_cnt_o), 32'h0);
    chk("rst_head",   32'(head_o),    32'h0);
    chk("rst_primed", 32'(primed_o),  32'h0);
    slice_i = '0; valid_i = '0;
    reset_i = 1'b1;
    for (int e = 1; e <= 4; e++) begin
      step();
      chk("prime_primed", 32'(primed_o), (e == 4) ? 32'h1 : 32'h0);
      chk("prime_dout",   32'(dout_o),   32'h0);
    end

    // Back-to-back staggered stream from the table.
    for (int cc = 0; cc < L + 3; cc++) begin
      drive_stream(cc);
      head_exp = slice_i[N*W-1 -: W];
      step();
      chk("stream_head", 32'(head_o), 32'(head_exp));
      if (cc >= 3) check_word("stream", cc - 3);
    end

    // Saturation with slice 2 tag missing on every word, then clear.
    slice_i = 12'h5A5; valid_i = 4'b1011;
    repeat (300) step();
    chk("sat_cnt", 32'(err_cnt_o), 32'd255);
    chk("sat_err", 32'(err_o),     32'h1);
    clr_err_i = 1'b1;
    step();
    chk("clr_vs_inc", 32'(err_cnt_o), 32'd0);
    clr_err_i = 1'b0;
    step();
    chk("inc_after_clr", 32'(err_cnt_o), 32'd1);
    step();
    chk("inc_after_clr2", 32'(err_cnt_o), 32'd2);
    stall_i = 1'b1; clr_err_i = 1'b1; slice_i = 12'h0F0; valid_i = 4'hF;
    step();
    chk("clr_in_stall_cnt",  32'(err_cnt_o), 32'd0);
    chk("clr_in_stall_dout", 32'(dout_o),    32'h5A5);
    chk("clr_in_stall_err",  32'(err_o),     32'h1);
    stall_i = 1'b0; clr_err_i = 1'b0;

    // Reset in the middle of a stream discards everything in flight.
    for (int cc = 0; cc < 3; cc++) begin
      drive_stream(cc);
      step();
    end
    #2 reset_i = 1'b0;
    #1;
    chk("midrst_dout",   32'(dout_o),    32'h0);
    chk("midrst_cnt",    32'(err_cnt_o), 32'h0);
    chk("midrst_primed", 32'(primed_o),  32'h0);
    chk("midrst_head",   32'(head_o),    32'h0);
    step();
    slice_i = '0; valid_i = '0;
    reset_i = 1'b1;

    // Same stream with a 3-cycle stall before word 5's slice 0 is accepted.
    c = 0;
    stalls = 0;
    while (c < L + 3) begin
      drive_stream(c);
      if (c == 5 && stalls < 3) begin
        stall_i = 1'b1;
        step();
        stalls++;
        check_word("stall_hold", 1);
      end else begin
        stall_i = 1'b0;
        step();
        if (c < 4) chk("stall_primed", 32'(primed_o), (c >= 3) ? 32'h1 : 32'h0);
        if (c >= 3) check_word("stall_run", c - 3);
        else chk("stall_pre_dout", 32'(dout_o), 32'h0);
        c++;
      end
    end
    stall_i = 1'b0;

    // Bypass: single-edge latency, then drop back to align mid-stream.
    bypass_i = 1'b1; slice_i = 12'h5A5; valid_i = 4'hF;
    step();
    chk("byp_dout",  32'(dout_o),  32'h5A5);
    chk("byp_valid", 32'(valid_o), 32'h1);
    chk("byp_err",   32'(err_o),   32'h0);
    valid_i = 4'b1011;
    step();
    chk("byp_mixed_valid", 32'(valid_o), 32'h0);
    chk("byp_mixed_err",   32'(err_o),   32'h1);
    for (int cc = 0; cc < 7; cc++) begin
      bypass_i = (cc < 4);
      drive_stream(cc);
      raw = slice_i;
      step();
      if (cc < 4) begin
        chk("byp_raw", 32'(dout_o), 32'(raw));
      end else begin
        chk("byp_exit_dout",  32'(dout_o),  32'(tbl[cc-3].exp_dout));
        chk("byp_exit_valid", 32'(valid_o), 32'(tbl[cc-3].exp_valid));
      end
    end
    bypass_i = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
